// File: rtl/mcu_pkg.sv
// Shared memory-control-unit definitions: width helpers, tag layout and the
// default BRAM read latency used by the BRAM wrappers and their arbiters.
package mcu_pkg;

  localparam int MCU_READ_LATENCY = 2;
  localparam int TAG_VALID_W      = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Index fields keep at least one bit so single-requester builds stay legal.
  function automatic int idx_width(input int num_req);
    return (clog2(num_req) < 1) ? 1 : clog2(num_req);
  endfunction

  // Tag layout is {valid, index}.
  function automatic int tag_width(input int num_req);
    return TAG_VALID_W + idx_width(num_req);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping; returns both a one-hot grant and its encoded index.
module rr_arbiter
  import mcu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int   cand;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == cand) && elig[i]) begin
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Shares one read-only BRAM port among NUM_REQ single-word readers, tracking
// each in-flight read with a tag pipeline and holding each reply until taken.
module bram_read_arbiter
  import mcu_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = MCU_READ_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arb_enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          bram_en,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [DATA_WIDTH-1:0]         bram_rddata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic                          idle
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int TAG_W = tag_width(NUM_REQ);

  logic [IDX_W-1:0]                   ptr_q, ptr_d;
  logic [NUM_REQ-1:0]                 inflight, busy, elig, grant, tail_hit;
  logic [IDX_W-1:0]                   grant_idx;
  logic [READ_LATENCY-1:0][TAG_W-1:0] tag_q;
  logic [READ_LATENCY-1:0]            tag_valid;
  logic [TAG_W-1:0]                   tail_tag;
  logic                               tail_valid;
  logic [IDX_W-1:0]                   tail_idx;
  logic [ADDR_WIDTH-1:0]              sel_addr, addr_hold_q;

  assign tail_tag   = tag_q[READ_LATENCY-1];
  assign tail_valid = tail_tag[TAG_W-1];
  assign tail_idx   = tail_tag[IDX_W-1:0];

  always_comb begin
    tag_valid = '0;
    inflight  = '0;
    for (int s = 0; s < READ_LATENCY; s++) begin
      tag_valid[s] = tag_q[s][TAG_W-1];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag_q[s][TAG_W-1] && (tag_q[s][IDX_W-1:0] == IDX_W'(i))) begin
          inflight[i] = 1'b1;
        end
      end
    end
  end

  // A requester stays ineligible until its held reply has been consumed.
  assign busy = inflight | rsp_valid;
  assign elig = req_valid & ~busy & {NUM_REQ{arb_enable}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .elig      (elig),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign bram_en   = |grant;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign bram_addr = bram_en ? sel_addr : addr_hold_q;

  always_comb begin
    ptr_d = ptr_q;
    if (bram_en) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      addr_hold_q <= '0;
      tag_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (bram_en) begin
        addr_hold_q <= sel_addr;
      end
      tag_q[0] <= bram_en ? {1'b1, grant_idx} : '0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      logic                  valid_q;
      logic [DATA_WIDTH-1:0] data_q;

      assign tail_hit[gi] = tail_valid && (tail_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (tail_hit[gi]) begin
          valid_q <= 1'b1;
          data_q  <= bram_rddata;
        end else if (valid_q && rsp_ready[gi]) begin
          valid_q <= 1'b0;
        end
      end

      assign rsp_valid[gi]                            = valid_q;
      assign rsp_data[gi*DATA_WIDTH +: DATA_WIDTH]    = data_q;
    end
  endgenerate

  assign idle = ~|tag_valid & ~|rsp_valid;

  // Grants are withheld while busy, so a returning word never lands on a held one.
  assert property (@(posedge clk) disable iff (rst) !(|(tail_hit & rsp_valid)));
  assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench: a 4-requester/latency-2 instance and a 1-requester/latency-1
// instance, each fed by a simple pipelined BRAM model.
module tb_bram_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_arb_enable;
  logic [3:0]   a_req_valid;
  logic [127:0] a_req_addr;
  logic [3:0]   a_req_ready;
  logic         a_bram_en;
  logic [31:0]  a_bram_addr;
  logic [15:0]  a_bram_rddata;
  logic [3:0]   a_rsp_valid;
  logic [63:0]  a_rsp_data;
  logic [3:0]   a_rsp_ready;
  logic         a_idle;

  logic         b_arb_enable;
  logic [0:0]   b_req_valid;
  logic [31:0]  b_req_addr;
  logic [0:0]   b_req_ready;
  logic         b_bram_en;
  logic [31:0]  b_bram_addr;
  logic [15:0]  b_bram_rddata;
  logic [0:0]   b_rsp_valid;
  logic [15:0]  b_rsp_data;
  logic [0:0]   b_rsp_ready;
  logic         b_idle;

  int n_cmp = 0;
  int n_err = 0;
  int bp_exp [19] = '{3, 0, 1, 2, 3, 0, 1, -1, 3, 0, 1, -1, 3, 0, 1, -1, 2, 3, 0};

  bram_read_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .READ_LATENCY(2)
  ) dut_a (
    .clk(clk), .rst(rst), .arb_enable(a_arb_enable),
    .req_valid(a_req_valid), .req_addr(a_req_addr), .req_ready(a_req_ready),
    .bram_en(a_bram_en), .bram_addr(a_bram_addr), .bram_rddata(a_bram_rddata),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_ready(a_rsp_ready),
    .idle(a_idle)
  );

  bram_read_arbiter #(
    .NUM_REQ(1), .ADDR_WIDTH(32), .DATA_WIDTH(16), .READ_LATENCY(1)
  ) dut_b (
    .clk(clk), .rst(rst), .arb_enable(b_arb_enable),
    .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
    .bram_en(b_bram_en), .bram_addr(b_bram_addr), .bram_rddata(b_bram_rddata),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_ready(b_rsp_ready),
    .idle(b_idle)
  );

  function automatic logic [15:0] bram_word(input logic [31:0] a);
    return a[15:0] ^ 16'hBEFF;
  endfunction

  function automatic logic [31:0] pa(input int i);
    return 32'h100 + 32'(i * 16);
  endfunction

  // BRAM models: not reset, so stale words still come back after a reset.
  logic [15:0] a_s1 = '0, a_s2 = '0, b_s1 = '0;
  always @(posedge clk) begin
    if (a_bram_en) a_s1 <= bram_word(a_bram_addr);
    a_s2 <= a_s1;
    if (b_bram_en) b_s1 <= bram_word(b_bram_addr);
  end
  assign a_bram_rddata = a_s2;
  assign b_bram_rddata = b_s1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    logic [6:0] b_en_pat;
    logic [6:0] b_rv_pat;
    int g;
    b_en_pat = 7'b1001001;
    b_rv_pat = 7'b0100100;

    rst = 1'b1;
    a_arb_enable = 1'b1; a_req_valid = '0; a_req_addr = '0; a_rsp_ready = '0;
    b_arb_enable = 1'b1; b_req_valid = '0; b_req_addr = '0; b_rsp_ready = '0;
    repeat (3) cyc();

    rst = 1'b0; settle();
    chk("reset_req_ready", 64'(a_req_ready), 64'h0);
    chk("reset_bram_en", 64'(a_bram_en), 64'h0);
    chk("reset_bram_addr", 64'(a_bram_addr), 64'h0);
    chk("reset_rsp_valid", 64'(a_rsp_valid), 64'h0);
    chk("reset_rsp_data", a_rsp_data, 64'h0);
    chk("reset_idle", 64'(a_idle), 64'h1);
    chk("reset_b_idle", 64'(b_idle), 64'h1);
    $display("step reset: %0d compared so far", n_cmp);

    // single read to requester 0
    cyc(); a_req_addr[31:0] = 32'h10; a_req_valid = 4'b0001; settle();
    chk("single_ready", 64'(a_req_ready), 64'h1);
    chk("single_en", 64'(a_bram_en), 64'h1);
    chk("single_addr", 64'(a_bram_addr), 64'h10);
    cyc(); a_req_valid = '0; settle();
    chk("single_t1_rsp_valid", 64'(a_rsp_valid), 64'h0);
    chk("single_t1_idle", 64'(a_idle), 64'h0);
    chk("single_t1_en", 64'(a_bram_en), 64'h0);
    chk("single_t1_addr_hold", 64'(a_bram_addr), 64'h10);
    cyc(); settle();
    chk("single_t2_rsp_valid", 64'(a_rsp_valid), 64'h0);
    cyc(); a_rsp_ready = 4'b0001; settle();
    chk("single_t3_rsp_valid", 64'(a_rsp_valid), 64'h1);
    chk("single_t3_rsp_data", 64'(a_rsp_data[15:0]), 64'hBEEF);
    cyc(); a_rsp_ready = '0; settle();
    chk("single_t4_rsp_valid", 64'(a_rsp_valid), 64'h0);
    chk("single_t4_idle", 64'(a_idle), 64'h1);
    $display("step single_read: %0d compared so far", n_cmp);

    // full contention, pointer starts at 1 after the single read
    cyc();
    for (int i = 0; i < 4; i++) a_req_addr[i*32 +: 32] = pa(i);
    a_req_valid = 4'hF; a_rsp_ready = 4'hF; settle();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin cyc(); settle(); end
      g = (1 + c) % 4;
      chk("contend_grant", 64'(a_req_ready), 64'(4'b0001 << g));
      chk("contend_addr", 64'(a_bram_addr), 64'(pa(g)));
      if (c >= 3) begin
        g = (c + 2) % 4;
        chk("contend_rsp_valid", 64'(a_rsp_valid), 64'(4'b0001 << g));
        chk("contend_rsp_data", 64'(a_rsp_data[g*16 +: 16]), 64'(bram_word(pa(g))));
      end else begin
        chk("contend_rsp_early", 64'(a_rsp_valid), 64'h0);
      end
    end
    cyc(); a_req_valid = '0; settle();
    repeat (3) begin cyc(); settle(); end
    chk("contend_drain_idle", 64'(a_idle), 64'h1);
    $display("step contention: %0d compared so far", n_cmp);

    // backpressure on requester 2, pointer starts at 3
    cyc(); a_req_valid = 4'hF; a_rsp_ready = 4'b1011; settle();
    for (int c = 0; c < 19; c++) begin
      if (c > 0) begin
        cyc();
        if (c == 15) a_rsp_ready = 4'hF;
        settle();
      end
      g = bp_exp[c];
      chk("bp_grant", 64'(a_req_ready), (g < 0) ? 64'h0 : 64'(4'b0001 << g));
      chk("bp_en", 64'(a_bram_en), (g < 0) ? 64'h0 : 64'h1);
      if (c >= 6 && c <= 15) begin
        chk("bp_rsp2_held", 64'(a_rsp_valid[2]), 64'h1);
        chk("bp_rsp2_data", 64'(a_rsp_data[47:32]), 64'hBFDF);
      end
      if (c == 16) chk("bp_rsp2_cleared", 64'(a_rsp_valid[2]), 64'h0);
    end
    cyc(); a_req_valid = '0; settle();
    repeat (3) begin cyc(); settle(); end
    chk("bp_drain_idle", 64'(a_idle), 64'h1);
    $display("step backpressure: %0d compared so far", n_cmp);

    // enable gating with two reads in flight, pointer starts at 1
    cyc(); a_rsp_ready = '0; a_req_valid = 4'b0011; settle();
    chk("gate_grant1", 64'(a_req_ready), 64'h2);
    chk("gate_addr1", 64'(a_bram_addr), 64'h110);
    cyc(); settle();
    chk("gate_grant0", 64'(a_req_ready), 64'h1);
    chk("gate_addr0", 64'(a_bram_addr), 64'h100);
    cyc(); a_arb_enable = 1'b0; a_req_valid = 4'b1100; settle();
    chk("gate_blocked_ready", 64'(a_req_ready), 64'h0);
    chk("gate_blocked_en", 64'(a_bram_en), 64'h0);
    chk("gate_addr_hold", 64'(a_bram_addr), 64'h100);
    cyc(); settle();
    chk("gate_rsp1_valid", 64'(a_rsp_valid), 64'h2);
    chk("gate_rsp1_data", 64'(a_rsp_data[31:16]), 64'hBFEF);
    chk("gate_busy_idle", 64'(a_idle), 64'h0);
    cyc(); settle();
    chk("gate_rsp_both", 64'(a_rsp_valid), 64'h3);
    chk("gate_rsp0_data", 64'(a_rsp_data[15:0]), 64'hBFFF);
    chk("gate_still_blocked", 64'(a_bram_en), 64'h0);
    cyc(); a_rsp_ready = 4'b0011; settle();
    chk("gate_held_idle", 64'(a_idle), 64'h0);
    cyc(); a_rsp_ready = '0; settle();
    chk("gate_drained_valid", 64'(a_rsp_valid), 64'h0);
    chk("gate_drained_idle", 64'(a_idle), 64'h1);
    chk("gate_drained_en", 64'(a_bram_en), 64'h0);
    cyc(); a_req_valid = '0; a_arb_enable = 1'b1; settle();
    chk("gate_reenable_en", 64'(a_bram_en), 64'h0);
    $display("step enable_gating: %0d compared so far", n_cmp);

    // reset one cycle after a grant; pointer is 1 beforehand
    cyc(); a_req_valid = 4'b0001; settle();
    chk("rst_pre_grant", 64'(a_req_ready), 64'h1);
    cyc(); rst = 1'b1; a_req_valid = '0; settle();
    cyc(); rst = 1'b0; settle();
    chk("rst_r2_rsp_valid", 64'(a_rsp_valid), 64'h0);
    chk("rst_r2_idle", 64'(a_idle), 64'h1);
    cyc(); settle();
    chk("rst_r3_rsp_valid", 64'(a_rsp_valid), 64'h0);
    chk("rst_r3_idle", 64'(a_idle), 64'h1);
    cyc(); settle();
    chk("rst_r4_rsp_valid", 64'(a_rsp_valid), 64'h0);
    cyc(); a_req_valid = 4'b0011; settle();
    chk("rst_ptr_zero_grant", 64'(a_req_ready), 64'h1);
    cyc(); a_req_valid = '0; a_rsp_ready = 4'hF; settle();
    cyc(); settle();
    cyc(); settle();
    chk("rst_post_rsp_valid", 64'(a_rsp_valid), 64'h1);
    chk("rst_post_rsp_data", 64'(a_rsp_data[15:0]), 64'hBFFF);
    cyc(); settle();
    chk("rst_post_idle", 64'(a_idle), 64'h1);
    $display("step reset_mid_op: %0d compared so far", n_cmp);

    // single requester, latency 1: reads every third cycle
    cyc(); b_req_addr = 32'h40; b_req_valid = 1'b1; b_rsp_ready = 1'b1; settle();
    for (int e = 0; e < 7; e++) begin
      if (e > 0) begin cyc(); settle(); end
      chk("b_rate_en", 64'(b_bram_en), 64'(b_en_pat[e]));
      chk("b_rate_rsp_valid", 64'(b_rsp_valid), 64'(b_rv_pat[e]));
      if (b_rv_pat[e]) chk("b_rate_rsp_data", 64'(b_rsp_data), 64'hBEBF);
    end
    cyc(); settle();
    chk("b_busy_ready", 64'(b_req_ready), 64'h0);
    chk("b_busy_en", 64'(b_bram_en), 64'h0);
    cyc(); b_req_valid = '0; settle();
    chk("b_drop_en", 64'(b_bram_en), 64'h0);
    chk("b_drop_rsp_valid", 64'(b_rsp_valid), 64'h1);
    cyc(); settle();
    chk("b_final_en", 64'(b_bram_en), 64'h0);
    chk("b_final_idle", 64'(b_idle), 64'h1);
    chk("b_addr_hold", 64'(b_bram_addr), 64'h40);
    $display("step single_requester: %0d compared so far", n_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
